// File: rtl/adc_bus_if.sv
// Command, read-return and peripheral bus signals of the ADC bus master.
// Command handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// rd_valid is a one-cycle pulse with no backpressure.
interface adc_bus_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [4:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic [7:0]  cmd_len;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        rd_last;
   logic        busy;
   logic [4:0]  bus_addr;
   logic        bus_csel;
   logic        bus_rd;
   logic        bus_wr;
   logic [15:0] bus_dout;
   logic        bus_oe;
   logic [15:0] bus_din;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_len, bus_din,
      output cmd_ready, rd_valid, rd_data, rd_last, busy,
             bus_addr, bus_csel, bus_rd, bus_wr, bus_dout, bus_oe
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_len, bus_din,
      input  cmd_ready, rd_valid, rd_data, rd_last, busy,
             bus_addr, bus_csel, bus_rd, bus_wr, bus_dout, bus_oe
   );
endinterface

// File: rtl/adc_bus_master.sv
// Parallel peripheral bus master: setup/strobe/hold cycles with active-low strobes,
// single writes and multi-word reads at a fixed address.
module adc_bus_master #(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   adc_bus_if.master  m,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [7:0]  words, words_nxt;
   logic        wr_q, wr_nxt;
   logic [4:0]  addr_q, addr_nxt;
   logic [15:0] wdata_q, wdata_nxt;
   logic        accept;
   logic        rd_sample;

   assign m.cmd_ready = (state == IDLE);
   assign accept      = m.cmd_valid && (state == IDLE);
   assign rd_sample   = (state == STROBE) && (cnt == 4'd0) && !wr_q;
   assign dbg_state   = state;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      words_nxt = words;
      wr_nxt    = wr_q;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SETUP;
               cnt_nxt   = SETUP_LD;
               wr_nxt    = m.cmd_wr;
               addr_nxt  = m.cmd_addr;
               wdata_nxt = m.cmd_wdata;
               words_nxt = (m.cmd_wr || m.cmd_len == 8'd0) ? 8'd1 : m.cmd_len;
            end
         end
         SETUP: begin
            if (cnt == 4'd0) begin
               state_nxt = STROBE;
               cnt_nxt   = STROBE_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         STROBE: begin
            if (cnt == 4'd0) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         HOLD: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else if (words > 8'd1) begin
               // another word at the same address, no idle gap
               state_nxt = SETUP;
               cnt_nxt   = SETUP_LD;
               words_nxt = words - 8'd1;
            end else begin
               state_nxt = IDLE;
               words_nxt = 8'd0;
            end
         end
      endcase
   end

   // Bus outputs are decoded from the next state so they change on the same edge as it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         words      <= 8'd0;
         wr_q       <= 1'b0;
         addr_q     <= 5'd0;
         wdata_q    <= 16'd0;
         m.bus_csel <= 1'b1;
         m.bus_rd   <= 1'b1;
         m.bus_wr   <= 1'b1;
         m.bus_addr <= 5'd0;
         m.bus_oe   <= 1'b0;
         m.bus_dout <= 16'd0;
         m.busy     <= 1'b0;
         m.rd_valid <= 1'b0;
         m.rd_last  <= 1'b0;
         m.rd_data  <= 16'd0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         words      <= words_nxt;
         wr_q       <= wr_nxt;
         addr_q     <= addr_nxt;
         wdata_q    <= wdata_nxt;
         m.bus_csel <= (state_nxt == IDLE);
         m.bus_rd   <= !((state_nxt == STROBE) && !wr_nxt);
         m.bus_wr   <= !((state_nxt == STROBE) && wr_nxt);
         m.bus_addr <= (state_nxt == IDLE) ? 5'd0 : addr_nxt;
         m.bus_oe   <= (state_nxt != IDLE) && wr_nxt;
         m.bus_dout <= ((state_nxt != IDLE) && wr_nxt) ? wdata_nxt : 16'd0;
         m.busy     <= (state_nxt != IDLE);
         m.rd_valid <= rd_sample;
         m.rd_last  <= rd_sample && (words == 8'd1);
         if (rd_sample) m.rd_data <= m.bus_din;
      end
   end

endmodule

// File: tb/tb_adc_bus_master.sv
// Randomized bench for adc_bus_master: command driver, bus slave model, protocol
// monitor with expected queues, directed timing, reset-abort and parameter cases.
module tb_adc_bus_master;
   localparam int S = 1;
   localparam int T = 2;
   localparam int H = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   adc_bus_if a_if ();
   adc_bus_if b_if ();
   logic [1:0] a_state, b_state;

   adc_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
      .clk(clk), .rst_n(rst_n), .m(a_if), .dbg_state(a_state)
   );
   adc_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut_p (
      .clk(clk), .rst_n(rst_n), .m(b_if), .dbg_state(b_state)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q[$];     // read words expected on rd_data
   logic [15:0] fixed_q[$];   // optional fixed values for the next read windows
   logic [20:0] wr_exp_q[$];  // {addr, data} per write window
   logic [4:0]  raddr_q[$];   // address per read window
   int          csel_q[$];    // expected chip-select low run per command
   int          nword_q[$];   // words per read command
   bit          chk_en = 1'b1;
   int          n_rdv = 0;
   int          n_last = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- bus slave model ----------------
   logic        in_win = 1'b0;
   logic        fix_on = 1'b0;
   logic [15:0] fix_val = 16'd0;
   logic [15:0] last_din = 16'd0;

   always @(negedge clk) begin
      if (!chk_en || !rst_n) begin
         in_win = 1'b0;
         a_if.bus_din = 16'($urandom);
      end else if (!a_if.bus_rd) begin
         if (!in_win) begin
            fix_on = (fixed_q.size() > 0);
            if (fix_on) fix_val = fixed_q.pop_front();
         end
         a_if.bus_din = fix_on ? fix_val : 16'($urandom);
         last_din = a_if.bus_din;
         in_win = 1'b1;
      end else begin
         if (in_win) exp_q.push_back(last_din);
         in_win = 1'b0;
         a_if.bus_din = 16'($urandom);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic        p_rd = 1'b1, p_wr = 1'b1, p_csel = 1'b1;
   int          rd_run = 0, wr_run = 0, csel_run = 0, word_idx = 0, cur_n = 0;
   logic [20:0] e_wr;

   always @(negedge clk) begin
      #1;
      if (chk_en && rst_n) begin
         check("strobe_excl", 32'(a_if.bus_rd | a_if.bus_wr), 1);
         check("busy_csel", 32'(a_if.busy), 32'(!a_if.bus_csel));
         check("ready_idle", 32'(a_if.cmd_ready), 32'(!a_if.busy));
         if (!a_if.busy)
            check("idle_vals", {a_if.bus_csel, a_if.bus_rd, a_if.bus_wr, a_if.bus_oe,
                                a_if.bus_addr, a_if.bus_dout}, {4'b1110, 5'd0, 16'd0});
         if (!a_if.bus_rd && p_rd) begin
            if (raddr_q.size() == 0) check("rd_window_unexpected", 1, 0);
            else check("rd_addr", 32'(a_if.bus_addr), 32'(raddr_q.pop_front()));
         end
         if (!a_if.bus_wr && p_wr) begin
            if (wr_exp_q.size() == 0) check("wr_window_unexpected", 1, 0);
            else begin
               e_wr = wr_exp_q.pop_front();
               check("wr_addr", 32'(a_if.bus_addr), 32'(e_wr[20:16]));
               check("wr_data", {a_if.bus_oe, a_if.bus_dout}, {1'b1, e_wr[15:0]});
            end
         end
         if (a_if.bus_rd && !p_rd) check("rd_strobe_len", rd_run, T);
         if (a_if.bus_wr && !p_wr) check("wr_strobe_len", wr_run, T);
         if (a_if.bus_csel && !p_csel) begin
            if (csel_q.size() == 0) check("csel_unexpected", 1, 0);
            else check("csel_len", csel_run, csel_q.pop_front());
         end
         if (a_if.rd_valid) begin
            n_rdv++;
            if (a_if.rd_last) n_last++;
            if (exp_q.size() == 0) check("rd_valid_unexpected", 1, 0);
            else begin
               check("rd_data", 32'(a_if.rd_data), 32'(exp_q.pop_front()));
               if (word_idx == 0) begin
                  if (nword_q.size() == 0) begin
                     check("rd_cmd_unexpected", 1, 0);
                     cur_n = 1;
                  end else cur_n = nword_q.pop_front();
               end
               word_idx++;
               check("rd_last", 32'(a_if.rd_last), 32'(word_idx == cur_n));
               if (word_idx == cur_n) word_idx = 0;
            end
         end else begin
            check("rd_last_idle", 32'(a_if.rd_last), 0);
         end
         rd_run   = a_if.bus_rd   ? 0 : rd_run + 1;
         wr_run   = a_if.bus_wr   ? 0 : wr_run + 1;
         csel_run = a_if.bus_csel ? 0 : csel_run + 1;
         p_rd   = a_if.bus_rd;
         p_wr   = a_if.bus_wr;
         p_csel = a_if.bus_csel;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic wr, input logic [4:0] addr, input logic [15:0] data,
                        input logic [7:0] len, input bit keep, input bit track);
      int n;
      int waitc;
      a_if.cmd_wr    = wr;
      a_if.cmd_addr  = addr;
      a_if.cmd_wdata = data;
      a_if.cmd_len   = len;
      a_if.cmd_valid = 1'b1;
      waitc = 0;
      while (!a_if.cmd_ready && waitc < 3000) begin
         @(negedge clk);
         waitc++;
      end
      if (!a_if.cmd_ready) begin
         check("cmd_ready_timeout", 0, 1);
         a_if.cmd_valid = 1'b0;
         return;
      end
      n = wr ? 1 : ((len == 8'd0) ? 1 : int'(len));
      if (track) begin
         if (wr) wr_exp_q.push_back({addr, data});
         else begin
            for (int i = 0; i < n; i++) raddr_q.push_back(addr);
            nword_q.push_back(n);
         end
         csel_q.push_back(n * (S + T + H));
      end
      @(posedge clk);
      #1;
      if (!keep) a_if.cmd_valid = 1'b0;
      // scrambled payload while busy must have no effect
      a_if.cmd_wr    = 1'($urandom);
      a_if.cmd_addr  = 5'($urandom);
      a_if.cmd_wdata = 16'($urandom);
      a_if.cmd_len   = 8'($urandom);
   endtask

   task automatic wait_idle();
      int waitc;
      waitc = 0;
      @(negedge clk);
      while (a_if.busy && waitc < 3000) begin
         @(negedge clk);
         waitc++;
      end
      if (a_if.busy) check("idle_timeout", 1, 0);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int base_v, base_l, waitc;
      logic [6:0] csel_lo, wr_lo;
      a_if.cmd_valid = 1'b0; a_if.cmd_wr = 1'b0; a_if.cmd_addr = 5'd0;
      a_if.cmd_wdata = 16'd0; a_if.cmd_len = 8'd0;
      b_if.cmd_valid = 1'b0; b_if.cmd_wr = 1'b0; b_if.cmd_addr = 5'd0;
      b_if.cmd_wdata = 16'd0; b_if.cmd_len = 8'd0; b_if.bus_din = 16'd0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctrl", {a_if.bus_csel, a_if.bus_rd, a_if.bus_wr, a_if.bus_oe, a_if.busy,
                         a_if.rd_valid, a_if.rd_last, a_if.cmd_ready}, 8'b1110_0001);
      check("rst_rd_data", 32'(a_if.rd_data), 0);
      check("rst_addr_dout", {a_if.bus_addr, a_if.bus_dout}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single write, cycle-exact
      issue(1'b1, 5'd21, 16'h00A5, 8'd0, 1'b0, 1'b1);
      @(negedge clk);
      check("w_cycle1", {a_if.bus_csel, a_if.bus_addr, a_if.bus_oe, a_if.bus_dout, a_if.bus_wr, a_if.bus_rd},
            {1'b0, 5'd21, 1'b1, 16'h00A5, 1'b1, 1'b1});
      @(negedge clk);
      check("w_cycle2", {a_if.bus_csel, a_if.bus_wr, a_if.bus_rd}, 3'b001);
      @(negedge clk);
      check("w_cycle3", {a_if.bus_csel, a_if.bus_wr, a_if.bus_rd}, 3'b001);
      @(negedge clk);
      check("w_cycle4", {a_if.bus_csel, a_if.bus_wr, a_if.bus_oe, a_if.bus_dout}, {3'b011, 16'h00A5});
      @(negedge clk);
      check("w_cycle5", {a_if.cmd_ready, a_if.bus_csel}, 2'b11);

      // three-word read with fixed bus data
      fixed_q.push_back(16'h1111); fixed_q.push_back(16'h2222); fixed_q.push_back(16'h3333);
      base_v = n_rdv; base_l = n_last;
      issue(1'b0, 5'd20, 16'd0, 8'd3, 1'b0, 1'b1);
      wait_idle();
      check("len3_pulses", n_rdv - base_v, 3);
      check("len3_last", n_last - base_l, 1);

      // len 0 reads one word
      base_v = n_rdv; base_l = n_last;
      issue(1'b0, 5'd20, 16'd0, 8'd0, 1'b0, 1'b1);
      wait_idle();
      check("len0_pulses", n_rdv - base_v, 1);
      check("len0_last", n_last - base_l, 1);

      // maximum length read
      base_v = n_rdv; base_l = n_last;
      issue(1'b0, 5'd7, 16'd0, 8'd255, 1'b0, 1'b1);
      wait_idle();
      check("len255_pulses", n_rdv - base_v, 255);
      check("len255_last", n_last - base_l, 1);

      // cmd_valid held high, alternating writes to 22 and 23
      for (int i = 0; i < 6; i++)
         issue(1'b1, (i % 2) ? 5'd23 : 5'd22, 16'($urandom), 8'd0, 1'b1, 1'b1);
      a_if.cmd_valid = 1'b0;
      wait_idle();

      // random traffic
      for (int i = 0; i < 40; i++) begin
         issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom),
               8'($urandom_range(0, 6)), 1'b0, 1'b1);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();

      // reset during the second strobe cycle of a read
      issue(1'b0, 5'd20, 16'd0, 8'd3, 1'b0, 1'b0);
      chk_en = 1'b0;
      waitc = 0;
      while (a_if.bus_rd && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      check("abort_strobe_seen", 32'(a_if.bus_rd), 0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_idle", {a_if.bus_csel, a_if.bus_rd, a_if.bus_wr, a_if.bus_oe, a_if.busy, a_if.rd_valid},
            6'b111000);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_no_rdv", 32'(a_if.rd_valid), 0);
      end
      p_rd = 1'b1; p_wr = 1'b1; p_csel = 1'b1;
      rd_run = 0; wr_run = 0; csel_run = 0; word_idx = 0;
      chk_en = 1'b1;
      issue(1'b0, 5'd9, 16'd0, 8'd2, 1'b0, 1'b1);
      wait_idle();

      // SETUP=3, STROBE=1, HOLD=2 write
      b_if.cmd_wr = 1'b1; b_if.cmd_addr = 5'd5; b_if.cmd_wdata = 16'hBEEF; b_if.cmd_len = 8'd0;
      b_if.cmd_valid = 1'b1;
      check("p_ready", 32'(b_if.cmd_ready), 1);
      @(posedge clk);
      #1;
      b_if.cmd_valid = 1'b0;
      csel_lo = '0; wr_lo = '0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         csel_lo[c] = !b_if.bus_csel;
         wr_lo[c]   = !b_if.bus_wr;
      end
      check("p_csel_cycles", 32'(csel_lo), 32'(7'b0111111));
      check("p_wr_cycles", 32'(wr_lo), 32'(7'b0001000));

      repeat (3) @(negedge clk);
      check("end_exp_q", exp_q.size(), 0);
      check("end_raddr_q", raddr_q.size(), 0);
      check("end_wr_q", wr_exp_q.size(), 0);
      check("end_csel_q", csel_q.size(), 0);
      check("end_nword_q", nword_q.size(), 0);
      check("end_word_idx", word_idx, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
